pc_sequencer: RTL and testbench

Program-counter sequencer and redirect controller for the core's fetch path. It owns the PC register and consumes the taken/not-taken decision of the `branch` unit for the instruction in EX. It steers fetch to the JAL/JALR/branch target and flushes wrong-path instructions already in IF/ID. It traps on misaligned targets.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer_target_calc.sv | 28 ++
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: control-transfer opcodes and the PC sequencer state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// EX-stage redirect inputs and fetch-control outputs of the PC sequencer.
interface pc_sequencer_if #(parameter int BITS = 32);

    logic            stall;
    logic            ex_valid;
    logic [31:0]     instruction;
    logic [BITS-1:0] ex_pc;
    logic [BITS-1:0] a;
    logic [BITS-1:0] imm;
    logic            branch;
    logic [BITS-1:0] pc;
    logic            fetch_en;
    logic            flush;
    logic            redirect;
    logic            trap;

    modport master (
        output stall, ex_valid, instruction, ex_pc, a, imm, branch,
        input  pc, fetch_en, flush, redirect, trap
    );

    modport slave (
        input  stall, ex_valid, instruction, ex_pc, a, imm, branch,
        output pc, fetch_en, flush, redirect, trap
    );

endinterface

// File: rtl/pc_sequencer_target_calc.sv
// Control-transfer target adder: JALR uses rs1 with bit 0 cleared, everything else is PC-relative.
module target_calc
    import riscv_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic [6:0]      opcode,
    input  logic [BITS-1:0] ex_pc,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] imm,
    output logic [BITS-1:0] target,
    output logic            misaligned
);

    logic [BITS-1:0] sum;

    always_comb begin
        if (opcode == OP_JALR) begin
            sum    = a + imm;
            target = {sum[BITS-1:1], 1'b0};
        end else begin
            sum    = ex_pc + imm;
            target = sum;
        end
        misaligned = (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequential increment, branch/jump redirect with a timed flush window, trap on misaligned targets.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter int              BITS         = 32,
    parameter logic [BITS-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    localparam logic [BITS-1:0] PC_STEP = BITS'(4);

    seq_state_t      state, state_next;
    logic [BITS-1:0] pc_q, pc_next, target;
    logic [2:0]      count, count_next;
    logic            redirect_q, redirect_next;
    logic            misaligned, take;
    logic            unused_instr_bits;

    assign unused_instr_bits = ^bus.instruction[31:7];
    assign take = bus.ex_valid & bus.branch & ~bus.stall;

    target_calc #(.BITS(BITS)) u_target_calc (
        .opcode     (bus.instruction[6:0]),
        .ex_pc      (bus.ex_pc),
        .a          (bus.a),
        .imm        (bus.imm),
        .target     (target),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc_q       <= RESET_PC;
            count      <= 3'd0;
            redirect_q <= 1'b0;
        end else begin
            state      <= state_next;
            pc_q       <= pc_next;
            count      <= count_next;
            redirect_q <= redirect_next;
        end
    end

    // In FLUSH, EX carries wrong-path instructions, so only the countdown matters there.
    always_comb begin
        state_next    = state;
        pc_next       = pc_q;
        count_next    = count;
        redirect_next = 1'b0;
        case (state)
            RUN: begin
                if (take) begin
                    if (misaligned) begin
                        state_next = HALT;
                    end else begin
                        pc_next       = target;
                        redirect_next = 1'b1;
                        count_next    = 3'(FLUSH_CYCLES);
                        state_next    = FLUSH;
                    end
                end else if (!bus.stall) begin
                    pc_next = pc_q + PC_STEP;
                end
            end
            FLUSH: begin
                if (!bus.stall) begin
                    pc_next    = pc_q + PC_STEP;
                    count_next = count - 3'd1;
                    if (count == 3'd1) begin
                        state_next = RUN;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_comb begin
        bus.fetch_en = (state != HALT);
        bus.flush    = (state != RUN);
        bus.trap     = (state == HALT);
        bus.pc       = pc_q;
        bus.redirect = redirect_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: table of per-cycle stimulus plus hand-written reset/trap sequences.
module tb_pc_sequencer;

    localparam logic [31:0] INSN_NOP    = 32'h0000_0013;
    localparam logic [31:0] INSN_BRANCH = 32'h0000_0063;
    localparam logic [31:0] INSN_JAL    = 32'h0000_006F;
    localparam logic [31:0] INSN_JALR   = 32'h0000_0067;
    localparam int          NUM_VECS    = 20;

    typedef struct {
        logic        stall;
        logic        ex_valid;
        logic        branch;
        logic [31:0] instruction;
        logic [31:0] ex_pc;
        logic [31:0] a;
        logic [31:0] imm;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic        exp_redirect;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [NUM_VECS];

    pc_sequencer_if #(.BITS(32)) bus ();

    pc_sequencer #(
        .BITS         (32),
        .RESET_PC     (32'h0),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic stall, input logic ex_valid, input logic branch,
                                   input logic [31:0] instruction, input logic [31:0] ex_pc,
                                   input logic [31:0] a, input logic [31:0] imm,
                                   input logic [31:0] exp_pc, input logic exp_flush,
                                   input logic exp_redirect);
        vec_t v;
        v.stall        = stall;
        v.ex_valid     = ex_valid;
        v.branch       = branch;
        v.instruction  = instruction;
        v.ex_pc        = ex_pc;
        v.a            = a;
        v.imm          = imm;
        v.exp_pc       = exp_pc;
        v.exp_flush    = exp_flush;
        v.exp_redirect = exp_redirect;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.stall       = v.stall;
        bus.ex_valid    = v.ex_valid;
        bus.branch      = v.branch;
        bus.instruction = v.instruction;
        bus.ex_pc       = v.ex_pc;
        bus.a           = v.a;
        bus.imm         = v.imm;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, idx, actual, expected);
        end
    endtask

    task automatic checkAll(input int idx, input logic [31:0] exp_pc, input logic exp_flush,
                            input logic exp_redirect, input logic exp_trap, input logic exp_fetch_en);
        checkOutput("pc",       idx, bus.pc,                exp_pc);
        checkOutput("flush",    idx, {31'd0, bus.flush},    {31'd0, exp_flush});
        checkOutput("redirect", idx, {31'd0, bus.redirect}, {31'd0, exp_redirect});
        checkOutput("trap",     idx, {31'd0, bus.trap},     {31'd0, exp_trap});
        checkOutput("fetch_en", idx, {31'd0, bus.fetch_en}, {31'd0, exp_fetch_en});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Each row: inputs held across one rising edge, outputs expected just after it.
        vecs[0]  = mkVec(0, 0, 0, INSN_NOP,    32'h0,        32'h0,   32'h0,  32'h0000_0004, 0, 0);
        vecs[1]  = mkVec(0, 0, 0, INSN_NOP,    32'h0,        32'h0,   32'h0,  32'h0000_0008, 0, 0);
        vecs[2]  = mkVec(0, 0, 0, INSN_NOP,    32'h0,        32'h0,   32'h0,  32'h0000_000C, 0, 0);
        vecs[3]  = mkVec(0, 1, 1, INSN_BRANCH, 32'h40,       32'h0,   32'h20, 32'h0000_0060, 1, 1);
        vecs[4]  = mkVec(0, 1, 1, INSN_BRANCH, 32'h40,       32'h0,   32'h20, 32'h0000_0064, 1, 0);
        vecs[5]  = mkVec(0, 1, 1, INSN_BRANCH, 32'h40,       32'h0,   32'h20, 32'h0000_0068, 0, 0);
        vecs[6]  = mkVec(0, 0, 1, INSN_BRANCH, 32'h40,       32'h0,   32'h20, 32'h0000_006C, 0, 0);
        vecs[7]  = mkVec(1, 1, 1, INSN_JAL,    32'h100,      32'h0,   32'h40, 32'h0000_006C, 0, 0);
        vecs[8]  = mkVec(1, 1, 1, INSN_JAL,    32'h100,      32'h0,   32'h40, 32'h0000_006C, 0, 0);
        vecs[9]  = mkVec(1, 1, 1, INSN_JAL,    32'h100,      32'h0,   32'h40, 32'h0000_006C, 0, 0);
        vecs[10] = mkVec(0, 1, 1, INSN_JAL,    32'h100,      32'h0,   32'h40, 32'h0000_0140, 1, 1);
        vecs[11] = mkVec(1, 0, 0, INSN_NOP,    32'h0,        32'h0,   32'h0,  32'h0000_0140, 1, 0);
        vecs[12] = mkVec(1, 0, 0, INSN_NOP,    32'h0,        32'h0,   32'h0,  32'h0000_0140, 1, 0);
        vecs[13] = mkVec(0, 0, 0, INSN_NOP,    32'h0,        32'h0,   32'h0,  32'h0000_0144, 1, 0);
        vecs[14] = mkVec(0, 0, 0, INSN_NOP,    32'h0,        32'h0,   32'h0,  32'h0000_0148, 0, 0);
        vecs[15] = mkVec(0, 1, 1, INSN_JALR,   32'h200,      32'h101, 32'h3,  32'h0000_0104, 1, 1);
        vecs[16] = mkVec(0, 0, 0, INSN_NOP,    32'h0,        32'h0,   32'h0,  32'h0000_0108, 1, 0);
        vecs[17] = mkVec(0, 0, 0, INSN_NOP,    32'h0,        32'h0,   32'h0,  32'h0000_010C, 0, 0);
        vecs[18] = mkVec(0, 1, 1, INSN_BRANCH, 32'hFFFF_FFF0, 32'h0,  32'h20, 32'h0000_0010, 1, 1);
        vecs[19] = mkVec(0, 0, 0, INSN_NOP,    32'h0,        32'h0,   32'h0,  32'h0000_0014, 1, 0);

        rst = 1'b1;
        applyStimulus(mkVec(0, 0, 0, INSN_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        step();
        step();
        rst = 1'b0;
        checkAll(100, 32'h0, 0, 0, 0, 1);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkAll(i, vecs[i].exp_pc, vecs[i].exp_flush, vecs[i].exp_redirect, 0, 1);
        end

        // Still mid-FLUSH here: reset must take effect without waiting for a clock edge.
        #2;
        rst = 1'b1;
        #1;
        checkAll(200, 32'h0, 0, 0, 0, 1);
        rst = 1'b0;
        applyStimulus(mkVec(0, 0, 0, INSN_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        step();
        checkAll(201, 32'h4, 0, 0, 0, 1);

        applyStimulus(mkVec(0, 1, 1, INSN_JALR, 32'h300, 32'h103, 32'h4, 32'h0, 0, 0));
        step();
        checkAll(300, 32'h4, 1, 0, 1, 0);
        applyStimulus(mkVec(0, 1, 1, INSN_BRANCH, 32'h40, 32'h0, 32'h20, 32'h0, 0, 0));
        step();
        checkAll(301, 32'h4, 1, 0, 1, 0);
        applyStimulus(mkVec(0, 0, 0, INSN_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        step();
        checkAll(302, 32'h4, 1, 0, 1, 0);

        #2;
        rst = 1'b1;
        #1;
        checkAll(303, 32'h0, 0, 0, 0, 1);
        rst = 1'b0;
        step();
        checkAll(304, 32'h4, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
